// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared core definitions used by the fetch stage and by decode.
//   RESET_PC_DEFAULT : first fetch address after reset
//   NOP_INST         : canonical NOP (addi x0, x0, 0)
//   PC_STEP          : sequential fetch increment
//   opcode_e         : major opcode encodings (inst[6:0])
//   fetch_entry_t    : PC + instruction pair held in the fetch buffer
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits of a
  // redirect target are simply discarded.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Decode uses this to pull the major opcode out of an instruction word.
  function automatic opcode_e getOpcode(input logic [31:0] instWord);
    return opcode_e'(instWord[6:0]);
  endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small circular FIFO of {PC, instruction} pairs between instruction memory
// and decode. A flush empties it in one cycle and wins over push and pop.
//   clock, reset             : clock, synchronous active-high reset
//   i_flush                  : discard every entry
//   i_push, i_pushPc/Inst    : write a new entry at the tail
//   i_pop                    : remove the head entry
//   o_valid                  : buffer is non-empty
//   o_headPc, o_headInst     : head entry contents
//   o_count                  : current occupancy
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [31:0]      i_pushPc,
  input  logic [31:0]      i_pushInst,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [31:0]      o_headPc,
  output logic [31:0]      o_headInst,
  output logic [CNT_W-1:0] o_count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_doPush;
  logic             w_doPop;
  fetch_entry_t     w_head;

  // Pointer wrap handles depths that are not a power of two.
  function automatic logic [PTR_W-1:0] nextIdx(input logic [PTR_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return '0;
    end
    return idx + PTR_W'(1);
  endfunction

  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; the fetch credit scheme keeps the full-without-pop case away.
  assign w_doPop  = i_pop && (r_count != '0) && !i_flush;
  assign w_doPush = i_push && !i_flush && ((r_count != FULL_CNT) || w_doPop);

  // Storage array carries no reset: the count and pointers decide what is
  // meaningful, so stale contents are never presented.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_tail] <= '{pc: i_pushPc, inst: i_pushInst};
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both return the
  // buffer to the empty state, and push/pop together leave occupancy as is.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_tail <= nextIdx(r_tail);
      end
      if (w_doPop) begin
        r_head <= nextIdx(r_head);
      end
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  assign w_head     = r_mem[r_head];
  assign o_valid    = (r_count != '0);
  assign o_headPc   = w_head.pc;
  assign o_headInst = w_head.inst;
  assign o_count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues word-aligned requests to instruction
// memory, buffers returned words with their PCs, and presents them to decode.
// Redirects flush the buffer and discard responses still owed for the old
// path.
//   clock, reset                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc       : taken branch / jump target
//   imem_req_valid/ready/addr         : request channel to instruction memory
//   imem_resp_valid/data              : in-order response channel
//   f_valid, f_pc, inst               : instruction presented to decode
//   d_ready                           : decode consumes the presented entry
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] inst,
  input  logic        d_ready
);

  localparam int               CNT_W     = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      r_fetchPc;
  logic [31:0]      r_respPc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;

  logic             w_fire;
  logic             w_credit;
  logic [CNT_W:0]   w_occupancy;
  logic [CNT_W-1:0] w_inflightNext;
  logic             w_dropping;
  logic             w_keepResp;
  logic             w_pop;
  logic [31:0]      w_redirectPc;
  logic             w_bufValid;
  logic [31:0]      w_headPc;
  logic [31:0]      w_headInst;
  logic [CNT_W-1:0] w_bufCount;

  // Credit: requests in flight plus entries already buffered may never
  // exceed the buffer size, so every kept response is guaranteed a slot.
  assign w_occupancy    = {1'b0, r_outstanding} + {1'b0, w_bufCount};
  assign w_credit       = (w_occupancy < OCC_LIMIT);
  assign imem_req_valid = !reset && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetchPc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  // In-flight count after this cycle. It includes requests whose responses
  // are going to be dropped, which is what a redirect or reset must skip.
  assign w_inflightNext = r_outstanding + CNT_W'(w_fire) - CNT_W'(imem_resp_valid);

  // Responses are in order, so every response seen while the drop counter
  // is non-zero belongs to an abandoned path.
  assign w_dropping   = (r_drop != '0);
  assign w_keepResp   = imem_resp_valid && !w_dropping && !redirect_valid && !reset;
  assign w_pop        = w_bufValid && d_ready && !redirect_valid && !reset;
  assign w_redirectPc = alignPc(redirect_pc);

  // Fetch PC and response-PC tracking. r_respPc is the PC of the next
  // response that will be kept; because responses return in order and all
  // dropped ones precede the kept ones, it only needs to restart at the
  // new path start and step by four per kept response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetchPc <= RESET_PC;
      r_respPc  <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetchPc <= w_redirectPc;
      r_respPc  <= w_redirectPc;
    end else begin
      if (w_fire) begin
        r_fetchPc <= r_fetchPc + PC_STEP;
      end
      if (w_keepResp) begin
        r_respPc <= r_respPc + PC_STEP;
      end
    end
  end

  // Outstanding and drop counters. On reset or redirect everything still
  // in flight (after this cycle's response, if any) becomes owed drops,
  // so late responses from the old path never reach the buffer. The
  // outstanding count keeps tracking those requests, which keeps the
  // total the memory can hold bounded by the buffer depth.
  always_ff @(posedge clock) begin
    if (reset || redirect_valid) begin
      r_outstanding <= w_inflightNext;
      r_drop        <= w_inflightNext;
    end else begin
      r_outstanding <= w_inflightNext;
      if (w_dropping && imem_resp_valid) begin
        r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .i_flush    (redirect_valid),
    .i_push     (w_keepResp),
    .i_pushPc   (r_respPc),
    .i_pushInst (imem_resp_data),
    .i_pop      (w_pop),
    .o_valid    (w_bufValid),
    .o_headPc   (w_headPc),
    .o_headInst (w_headInst),
    .o_count    (w_bufCount)
  );

  // Decode sees nothing while reset is held, and a NOP at PC 0 whenever the
  // buffer is empty, so downstream never latches stale data.
  assign f_valid = w_bufValid && !reset;
  assign f_pc    = f_valid ? w_headPc : 32'h0000_0000;
  assign inst    = f_valid ? w_headInst : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RST_PC    = 32'h0100_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] inst;
  logic        d_ready;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .f_valid         (f_valid),
    .f_pc            (f_pc),
    .inst            (inst),
    .d_ready         (d_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory-side view of an accepted request: the address actually sent,
  // the PC the reference expects, the path epoch, and when it may return.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          epoch;
    int          readyCycle;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } expEntry_t;

  memReq_t     memQ[$];
  expEntry_t   expQ[$];

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          epoch = 0;
  int          modelBuffered = 0;
  logic [31:0] modelPc = RST_PC;

  int          readyPct = 100;
  int          dReadyPct = 100;
  int          respPct = 100;
  int          latMin = 1;
  int          latMax = 1;
  int          redirectPct = 0;
  int          resetPct = 0;
  bit          forceReset = 1'b0;
  bit          forceRedirect = 1'b0;
  logic [31:0] forceTarget = '0;

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [31:0] randomTarget();
    case ($urandom_range(3))
      0:       return RST_PC + 32'($urandom_range(255));
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Drives one set of inputs per cycle, shortly after the rising edge.
  // The memory responder lives here: it returns the oldest accepted
  // request once its latency has elapsed.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cycle++;
      reset = forceReset || ($urandom_range(99) < resetPct);
      forceReset = 1'b0;
      if (forceRedirect) begin
        redirect_valid = 1'b1;
        redirect_pc    = forceTarget;
        forceRedirect  = 1'b0;
      end else begin
        redirect_valid = ($urandom_range(99) < redirectPct);
        redirect_pc    = randomTarget();
      end
      imem_req_ready = ($urandom_range(99) < readyPct);
      d_ready        = ($urandom_range(99) < dReadyPct);
      if (memQ.size() > 0 && memQ[0].readyCycle <= cycle && $urandom_range(99) < respPct) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memData(memQ[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  endtask

  // Reference model step, just after the falling edge. Checks request-side
  // and f_valid behaviour from the credit rule, then advances the model:
  // responses from the current epoch become expected decode entries, a
  // redirect or reset starts a new epoch and empties the expectation queue.
  task automatic modelStep();
    bit          expValid;
    bit          fire;
    bit          push;
    bit          pop;
    memReq_t     r;
    logic [31:0] expInst;
    expValid = !reset && !redirect_valid && ((memQ.size() + modelBuffered) < BUF_DEPTH);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(expValid));
    if (imem_req_valid && expValid) begin
      checkOutput("req_addr", imem_req_addr, modelPc);
    end
    checkOutput("f_valid", 32'(f_valid), 32'(!reset && modelBuffered > 0));
    fire = imem_req_valid && imem_req_ready;
    pop  = !reset && !redirect_valid && (modelBuffered > 0) && d_ready;
    push = 1'b0;
    if (imem_resp_valid && memQ.size() > 0) begin
      r = memQ.pop_front();
      if (!reset && !redirect_valid && r.epoch == epoch) begin
        expInst = memData(r.pc);
        expQ.push_back('{pc: r.pc, inst: expInst});
        push = 1'b1;
      end
    end
    if (fire) begin
      memQ.push_back('{addr: imem_req_addr, pc: modelPc, epoch: epoch,
                       readyCycle: cycle + int'($urandom_range(latMax, latMin))});
      modelPc = modelPc + 32'd4;
    end
    if (reset || redirect_valid) begin
      epoch++;
      expQ.delete();
      modelBuffered = 0;
      modelPc = reset ? RST_PC : {redirect_pc[31:2], 2'b00};
    end else begin
      modelBuffered = modelBuffered + int'(push) - int'(pop);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #1;
      modelStep();
    end
  end

  // Scoreboard monitor: whenever decode takes an entry, the oldest expected
  // entry is popped and compared; an empty buffer must show NOP at PC 0.
  initial begin
    expEntry_t e;
    forever begin
      @(negedge clock);
      if (f_valid && d_ready && !redirect_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pop: got pc %h with no expected entry (cycle %0d)", f_pc, cycle);
        end else begin
          e = expQ.pop_front();
          checkOutput("f_pc", f_pc, e.pc);
          checkOutput("inst", inst, e.inst);
        end
      end else if (!f_valid) begin
        checkOutput("empty_pc", f_pc, 32'h0);
        checkOutput("empty_inst", inst, NOP);
      end
    end
  end

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    d_ready         = 1'b1;

    resetPct = 100;
    applyStimulus(3);
    resetPct = 0;

    $display("[TB] sequential fetch, ideal memory");
    applyStimulus(12);

    $display("[TB] decode stall then drain");
    dReadyPct = 0;
    applyStimulus(5);
    dReadyPct = 100;
    applyStimulus(6);

    $display("[TB] redirect with requests in flight");
    latMin = 3;
    latMax = 3;
    applyStimulus(4);
    forceRedirect = 1'b1;
    forceTarget   = 32'h0100_0103;
    applyStimulus(12);
    latMin = 1;
    latMax = 1;

    $display("[TB] memory not ready");
    readyPct = 0;
    applyStimulus(3);
    readyPct = 100;
    applyStimulus(4);

    $display("[TB] address wrap");
    forceRedirect = 1'b1;
    forceTarget   = 32'hFFFF_FFF8;
    applyStimulus(8);

    $display("[TB] reset mid-operation");
    latMin = 2;
    latMax = 2;
    dReadyPct = 0;
    applyStimulus(4);
    forceReset = 1'b1;
    applyStimulus(1);
    dReadyPct = 100;
    applyStimulus(10);

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 60; blk++) begin
      readyPct    = int'($urandom_range(100, 30));
      dReadyPct   = int'($urandom_range(100, 20));
      respPct     = int'($urandom_range(100, 40));
      latMin      = 1;
      latMax      = int'($urandom_range(4, 1));
      redirectPct = int'($urandom_range(6));
      resetPct    = (blk % 10 == 9) ? 2 : 0;
      applyStimulus(50);
    end

    redirectPct = 0;
    resetPct    = 0;
    readyPct    = 0;
    dReadyPct   = 100;
    respPct     = 100;
    applyStimulus(20);
    checkOutput("drain_expected", 32'(expQ.size()), 32'h0);
    checkOutput("drain_memory", 32'(memQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h01000000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction-buffer entries; also the limit on in-flight plus buffered fetches.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  control-flow change (branch/jump taken) this cycle.
REQ-006 redirect_pc  input  32  new fetch address when redirect_valid=1.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  32  word-aligned fetch address.
REQ-010 imem_resp_valid  input  1  instruction word returned; in order, at least 1 cycle after acceptance.
REQ-011 imem_resp_data  input  32  returned instruction word.
REQ-012 f_valid  output  1  f_pc/inst valid toward decode.
REQ-013 f_pc  output  32  PC of presented instruction.
REQ-014 inst  output  32  presented instruction word.
REQ-015 d_ready  input  1  decode consumes the presented instruction.

Function
REQ-016 Request fires on imem_req_valid & imem_req_ready; fetch PC then advances by 4, wrapping modulo 2^32.
REQ-017 imem_req_valid SHALL be 1 only when outstanding + buffered < BUF_DEPTH, not in reset, and not in a redirect cycle.
REQ-018 imem_req_addr SHALL hold while imem_req_valid=1 and imem_req_ready=0.
REQ-019 Each non-dropped response SHALL be pushed to the buffer with its request PC; visible at f_valid the next cycle (no bypass).
REQ-020 f_valid = buffer non-empty; f_pc/inst = head entry; pop on f_valid & d_ready.
REQ-021 While f_valid=1 and d_ready=0, f_pc and inst SHALL hold stable.
REQ-022 When buffer is empty, inst SHALL be 32'h00000013 (NOP) and f_pc SHALL be 0.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; the credit rule (REQ-017) guarantees no overflow.
REQ-024 On redirect_valid: fetch PC <= {redirect_pc[31:2],2'b00}; buffer flushed; drop counter <= current outstanding count.
REQ-025 While drop counter > 0, each response SHALL be discarded and decrement it.
REQ-026 Redirect coinciding with a pop or a response: flush and drop accounting take priority; no entry is retained.
REQ-027 Redirect while already dropping: drop counter <= total outstanding count.
REQ-028 Back-to-back redirects: last one wins; no request issued until the cycle after the final redirect.
REQ-029 Outstanding counter SHALL increment on request fire and decrement on response, including both in the same cycle; width SHALL be clog2(BUF_DEPTH)+1.

Reset
REQ-030 While reset=1: fetch PC=RESET_PC, outstanding=0, drop=0, buffer empty, imem_req_valid=0, f_valid=0, f_pc=0, inst=NOP.
REQ-031 Reset mid-operation abandons in-flight requests; responses arriving after reset deasserts are discarded via drop counter loaded with outstanding count.
REQ-032 First request (addr RESET_PC) SHALL assert the cycle after reset deasserts.

Structure
REQ-033 RESET_PC default, NOP encoding 32'h00000013 and opcode constants SHALL live in the shared core package also used by decode.
REQ-034 The buffer SHALL be a sub-module fetch_buffer (parameterised FIFO, with flush, 32-bit PC + 32-bit instruction).

Verification
REQ-035 Reset release, memory always ready, 1-cycle latency, d_ready=1 -> f_pc sequence 0x01000000, 0x01000004, 0x01000008, one per cycle after fill.
REQ-036 d_ready=0 for 5 cycles -> two entries buffered, imem_req_valid=0, f_pc/inst stable; d_ready=1 -> in-order drain with no loss.
REQ-037 Redirect to 0x01000103 with 2 outstanding -> next request addr 0x01000100; both stale responses discarded; first f_pc=0x01000100.
REQ-038 imem_req_ready=0 for 3 cycles -> imem_req_addr held constant; no PC advance.
REQ-039 Fetch PC 0xFFFFFFFC -> next request addr 0x00000000.
REQ-040 reset asserted with 1 outstanding and 1 buffered -> f_valid=0 and inst=NOP next cycle; late response dropped; first f_pc=0x01000000.
